// File: rtl/spell_rambus_sram.sv
// rtl/spell_rambus_sram.sv - Wishbone classic slave bridging spell's rambus port to a 1-cycle-latency SRAM
// Optional out-of-range detection and sticky o_range_err port: define SPELL_RAMBUS_RANGE_ERR_EN.

module spell_rambus_sram #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 512
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_wb_cyc,
    input  logic                       i_wb_stb,
    input  logic                       i_wb_we,
    input  logic [ADDR_W-1:0]          i_wb_addr,
    input  logic [3:0]                 i_wb_sel,
    input  logic [31:0]                i_wb_data,
    output logic [31:0]                o_wb_data,
    output logic                       o_wb_ack,
    output logic                       o_sram_ce_n,
    output logic [3:0]                 o_sram_we_n,
    output logic [$clog2(DEPTH)-1:0]   o_sram_addr,
    output logic [31:0]                o_sram_d,
    input  logic [31:0]                i_sram_q
`ifdef SPELL_RAMBUS_RANGE_ERR_EN
    ,
    output logic                       o_range_err
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t          state, state_nx;
    logic            req;
    logic            addr_oor;
    logic            req_we, req_we_nx;
    logic            req_oor, req_oor_nx;
    logic            ack_nx;
    logic [31:0]     rdata_nx;
    logic            ce_n_nx;
    logic [3:0]      we_n_nx;
    logic [AW-1:0]   addr_nx;
    logic [31:0]     d_nx;

    assign req = i_wb_cyc & i_wb_stb;

`ifdef SPELL_RAMBUS_RANGE_ERR_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    assign addr_oor = ({1'b0, i_wb_addr} >= DEPTH_LIM);
`else
    // Upper address bits are intentionally dropped: out-of-range words alias.
    logic unused_addr_hi;
    assign addr_oor       = 1'b0;
    assign unused_addr_hi = ^i_wb_addr[ADDR_W-1:AW];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            o_wb_ack    <= 1'b0;
            o_wb_data   <= 32'h0;
            o_sram_ce_n <= 1'b1;
            o_sram_we_n <= 4'hF;
            o_sram_addr <= '0;
            o_sram_d    <= 32'h0;
            req_we      <= 1'b0;
            req_oor     <= 1'b0;
        end else begin
            state       <= state_nx;
            o_wb_ack    <= ack_nx;
            o_wb_data   <= rdata_nx;
            o_sram_ce_n <= ce_n_nx;
            o_sram_we_n <= we_n_nx;
            o_sram_addr <= addr_nx;
            o_sram_d    <= d_nx;
            req_we      <= req_we_nx;
            req_oor     <= req_oor_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ack_nx     = o_wb_ack;
        rdata_nx   = o_wb_data;
        ce_n_nx    = o_sram_ce_n;
        we_n_nx    = o_sram_we_n;
        addr_nx    = o_sram_addr;
        d_nx       = o_sram_d;
        req_we_nx  = req_we;
        req_oor_nx = req_oor;

        unique case (state)
            S_IDLE: begin
                if (req) begin
                    state_nx   = S_ISSUE;
                    addr_nx    = i_wb_addr[AW-1:0];
                    d_nx       = i_wb_data;
                    req_we_nx  = i_wb_we;
                    req_oor_nx = addr_oor;
                    // Out-of-range and empty-mask writes walk the FSM without touching the SRAM.
                    if (addr_oor || (i_wb_we && (i_wb_sel == 4'h0))) begin
                        ce_n_nx = 1'b1;
                        we_n_nx = 4'hF;
                    end else begin
                        ce_n_nx = 1'b0;
                        we_n_nx = i_wb_we ? ~i_wb_sel : 4'hF;
                    end
                end
            end
            S_ISSUE: begin
                ce_n_nx = 1'b1;
                we_n_nx = 4'hF;
                if (!i_wb_cyc) begin
                    state_nx = S_IDLE;
                end else if (req_we) begin
                    ack_nx   = 1'b1;
                    state_nx = S_ACK;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_wb_cyc) begin
                    state_nx = S_IDLE;
                end else begin
                    rdata_nx = req_oor ? 32'h0 : i_sram_q;
                    ack_nx   = 1'b1;
                    state_nx = S_ACK;
                end
            end
            S_ACK: begin
                ack_nx   = 1'b0;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

`ifdef SPELL_RAMBUS_RANGE_ERR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_range_err <= 1'b0;
        end else if ((state == S_IDLE) && req && addr_oor) begin
            o_range_err <= 1'b1;
        end
    end
`endif

endmodule
